stride_rpt_prefetcher: RTL and testbench
========================================

Name: stride_rpt_prefetcher

Overview:
Multi-entry, PC-indexed stride prefetcher (reference prediction table) for the data-side memory path. It trains on every data access, tracks per-PC last address, stride and saturating confidence, and emits DEGREE line-aligned prefetch addresses once confidence crosses a threshold. Requests are buffered in a small FIFO and issued to the prefetch port of the L2/arbiter with a read/resp handshake.

Parameters:
S_INDEX, 4, table index bits; entries = 2^S_INDEX
PC_LSB, 2, lowest PC bit used for indexing
DEGREE, 2, prefetch candidates generated per trigger (1..8)
CONF_BITS, 2, width of saturating confidence counter
CONF_THRESH, 2, confidence required to trigger (<= 2^CONF_BITS-1)
QDEPTH, 4, request FIFO depth (power of 2)
LINE_LOG, 5, log2 cache line bytes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  0 = training only; no new triggers
acc_valid  in  1  data access valid this cycle
acc_pc  in  32  PC of the access
acc_addr  in  32  byte address of the access
pf_read  out  1  prefetch request valid
pf_addr  out  32  line-aligned prefetch address
pf_resp  in  1  memory accepted/completed current request
drop_cnt  out  16  saturating count of candidates lost to full FIFO

Behaviour:
- Reset: all entry valid bits 0, FIFO empty, generator idle, last-pushed-line invalid, pf_read=0, pf_addr=0, drop_cnt=0. Reset overrides all activity, including an in-flight handshake; a pf_resp arriving after reset is ignored.
- Entry: valid, tag = pc[31:PC_LSB+S_INDEX], last_addr[31:0], stride[31:0] (two's complement), conf[CONF_BITS-1:0]. Index = pc[PC_LSB+S_INDEX-1:PC_LSB]. Read combinational; updated at the clock edge ending the acc_valid cycle.
- Miss (invalid or tag mismatch): allocate. valid=1, tag, last_addr=addr, stride=0, conf=0. No trigger.
- Hit: cur = addr - last_addr (mod 2^32).
  - cur==0: entry unchanged, no trigger.
  - cur==stride: conf = sat_inc(conf); last_addr=addr.
  - otherwise: stride=cur, conf=0, last_addr=addr.
  - Trigger iff enable && hit && cur==stride && stride!=0 && sat_inc(conf) >= CONF_THRESH.
- Generator: on trigger (edge ending cycle T), latch base=addr, stride, k=1. In cycles T+1..T+DEGREE it produces cand = (base + k*stride) with the low LINE_LOG bits cleared, one per cycle, k++. It goes idle after k=DEGREE. A new trigger while busy restarts it with the new base/stride (remaining candidates discarded).
- Line filter: a candidate whose line equals the base line or the last pushed line is skipped (no push, no drop).
- FIFO push: the candidate is pushed if not full, or if full with a pop in the same cycle. Otherwise it is dropped and drop_cnt increments, saturating at 0xFFFF.
- Issue: pf_read = FIFO non-empty; pf_addr = head (0 when empty). Both are stable until pf_resp. pf_resp while pf_read=1 pops at that edge; the next head is presented the following cycle. pf_resp while pf_read=0 is ignored.
- Latency: a candidate pushed at the edge ending T+1 gives pf_read=1 in T+2 when the FIFO was empty.
- Address arithmetic wraps mod 2^32. Training continues while the FIFO is full or enable=0. An already-running generator finishes when enable falls.

Test Plan:
1. PC=0x100, addrs 0x1000,0x1040,0x1080,0x10C0 on consecutive accesses -> no request until 4th; then pf_addr 0x1100 then 0x1140 (pf_resp each); FIFO empties, pf_read=0.
2. PC=0x200, addrs 0x3100,0x30C0,0x3080,0x3040 (stride -0x40) -> prefetches 0x3000, 0x2FC0.
3. PC=0x300, stride 4 from 0x2000 (4 accesses) -> trigger fires, all candidates lie in line 0x2000 and are skipped; pf_read stays 0, drop_cnt=0.
4. Train PC=0x100 to conf 2, then access PC=0x140 (same index, different tag), then PC=0x100 stride access -> reallocation; no trigger until re-trained (3 more strided accesses).
5. pf_resp held low; repeated triggers on a trained stride 0x40 stream -> FIFO holds 4 requests; each further candidate increments drop_cnt; releasing pf_resp drains the 4 heads in order.
6. Assert rst with FIFO at 3 entries and generator busy -> next cycle pf_read=0, pf_addr=0, drop_cnt=0; a prior trained PC misses and reallocates.

Source files
------------

// File: rtl/stride_rpt_prefetcher.sv
// PC-indexed stride prefetcher: a reference prediction table trains on data accesses and
// feeds a line-filtered candidate generator into a small request FIFO.
module stride_rpt_prefetcher #(
  parameter int S_INDEX     = 4,
  parameter int PC_LSB      = 2,
  parameter int DEGREE      = 2,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2,
  parameter int QDEPTH      = 4,
  parameter int LINE_LOG    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        acc_valid,
  input  logic [31:0] acc_pc,
  input  logic [31:0] acc_addr,
  output logic        pf_read,
  output logic [31:0] pf_addr,
  input  logic        pf_resp,
  output logic [15:0] drop_cnt
);
  localparam int ENTRIES = 1 << S_INDEX;
  localparam int TAG_W   = 32 - PC_LSB - S_INDEX;
  localparam int QA      = $clog2(QDEPTH);
  localparam int KW      = 4;
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
  localparam logic [CONF_BITS-1:0] THRESH   = CONF_BITS'(CONF_THRESH);
  localparam logic [KW-1:0]        K_LAST   = KW'(DEGREE);
  localparam logic [QA:0]          Q_FULL   = (QA+1)'(QDEPTH);
  localparam logic [31:0]          LINE_MASK = ~((32'd1 << LINE_LOG) - 32'd1);

  logic                 tbl_valid  [ENTRIES];
  logic [TAG_W-1:0]     tbl_tag    [ENTRIES];
  logic [31:0]          tbl_last   [ENTRIES];
  logic [31:0]          tbl_stride [ENTRIES];
  logic [CONF_BITS-1:0] tbl_conf   [ENTRIES];

  logic [S_INDEX-1:0]   idx;
  logic [TAG_W-1:0]     tag_in;
  logic                 hit;
  logic [31:0]          cur;
  logic [CONF_BITS-1:0] conf_inc;
  logic                 trigger;

  assign idx      = acc_pc[PC_LSB+S_INDEX-1:PC_LSB];
  assign tag_in   = acc_pc[31:PC_LSB+S_INDEX];
  assign hit      = tbl_valid[idx] && (tbl_tag[idx] == tag_in);
  assign cur      = acc_addr - tbl_last[idx];
  assign conf_inc = (tbl_conf[idx] == CONF_MAX) ? CONF_MAX : tbl_conf[idx] + 1'b1;
  assign trigger  = acc_valid && enable && hit && (cur == tbl_stride[idx]) &&
                    (tbl_stride[idx] != 32'd0) && (conf_inc >= THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl_valid[i] <= 1'b0;
    end else if (acc_valid && !hit) begin
      tbl_valid[idx] <= 1'b1;
    end
  end

  // A zero delta (repeat access to the same address) leaves the entry untouched.
  always_ff @(posedge clk) begin
    if (!rst && acc_valid) begin
      if (!hit) begin
        tbl_tag[idx]    <= tag_in;
        tbl_last[idx]   <= acc_addr;
        tbl_stride[idx] <= 32'd0;
        tbl_conf[idx]   <= '0;
      end else if (cur != 32'd0) begin
        tbl_last[idx] <= acc_addr;
        if (cur == tbl_stride[idx]) begin
          tbl_conf[idx] <= conf_inc;
        end else begin
          tbl_stride[idx] <= cur;
          tbl_conf[idx]   <= '0;
        end
      end
    end
  end

  logic              gen_busy;
  logic [31:0]       gen_base;
  logic [31:0]       gen_stride;
  logic [KW-1:0]     gen_k;
  logic [31:0]       cand;
  logic              cand_skip;
  logic              cand_ok;
  logic              last_valid;
  logic [31:LINE_LOG] last_line;

  assign cand      = (gen_base + gen_stride * {{(32-KW){1'b0}}, gen_k}) & LINE_MASK;
  assign cand_skip = (cand[31:LINE_LOG] == gen_base[31:LINE_LOG]) ||
                     (last_valid && (cand[31:LINE_LOG] == last_line));
  assign cand_ok   = gen_busy && !cand_skip;

  logic [31:0] q_mem [QDEPTH];
  logic [QA-1:0] rd_ptr, wr_ptr;
  logic [QA:0]   q_count;
  logic          q_empty, q_full, pop, push;

  assign q_empty = (q_count == '0);
  assign q_full  = (q_count == Q_FULL);
  assign pop     = pf_resp && !q_empty;
  assign push    = cand_ok && (!q_full || pop);
  assign pf_read = !q_empty;
  assign pf_addr = q_empty ? 32'd0 : q_mem[rd_ptr];

  // A fresh trigger takes priority over finishing the current burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_busy   <= 1'b0;
      gen_base   <= 32'd0;
      gen_stride <= 32'd0;
      gen_k      <= '0;
    end else if (trigger) begin
      gen_busy   <= 1'b1;
      gen_base   <= acc_addr;
      gen_stride <= cur;
      gen_k      <= KW'(1);
    end else if (gen_busy) begin
      if (gen_k == K_LAST) gen_busy <= 1'b0;
      else gen_k <= gen_k + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      q_count    <= '0;
      last_valid <= 1'b0;
      last_line  <= '0;
      drop_cnt   <= 16'd0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= cand;
        wr_ptr        <= wr_ptr + 1'b1;
        last_valid    <= 1'b1;
        last_line     <= cand[31:LINE_LOG];
      end else if (cand_ok && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

endmodule

// File: tb/tb_stride_rpt_prefetcher.sv
// Bench for stride_rpt_prefetcher: directed scenarios plus random traffic, all checked
// every cycle against a table/queue reference model.
module tb_stride_rpt_prefetcher;
  localparam int S_INDEX = 4, PC_LSB = 2, DEGREE = 2, CONF_BITS = 2;
  localparam int CONF_THRESH = 2, QDEPTH = 4, LINE_LOG = 5;
  localparam int ENTRIES = 1 << S_INDEX;
  localparam int CONF_MAX = (1 << CONF_BITS) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        acc_valid = 1'b0;
  logic [31:0] acc_pc = 32'd0;
  logic [31:0] acc_addr = 32'd0;
  logic        pf_read;
  logic [31:0] pf_addr;
  logic        pf_resp = 1'b0;
  logic [15:0] drop_cnt;

  int total = 0;
  int bad = 0;

  stride_rpt_prefetcher #(
    .S_INDEX(S_INDEX), .PC_LSB(PC_LSB), .DEGREE(DEGREE), .CONF_BITS(CONF_BITS),
    .CONF_THRESH(CONF_THRESH), .QDEPTH(QDEPTH), .LINE_LOG(LINE_LOG)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .acc_valid(acc_valid), .acc_pc(acc_pc),
    .acc_addr(acc_addr), .pf_read(pf_read), .pf_addr(pf_addr), .pf_resp(pf_resp),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // reference model state
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_last   [ENTRIES];
  logic [31:0] m_stride [ENTRIES];
  int          m_conf   [ENTRIES];
  logic [31:0] m_q[$];
  bit          m_busy;
  logic [31:0] m_base, m_gstride, m_k;
  bit          m_lvalid;
  logic [31:0] m_lline;
  int          m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    m_q.delete();
    m_busy = 0;
    m_lvalid = 0;
    m_drop = 0;
  endfunction

  function automatic void model_edge();
    int idx;
    logic [31:0] tag, c, d;
    bit trig;
    int nc;
    if (rst) begin
      model_reset();
      return;
    end
    if (pf_resp && m_q.size() > 0) void'(m_q.pop_front());
    if (m_busy) begin
      c = (m_base + m_k * m_gstride) & ~((32'd1 << LINE_LOG) - 1);
      if (!((c >> LINE_LOG) == (m_base >> LINE_LOG) || (m_lvalid && c == m_lline))) begin
        if (m_q.size() < QDEPTH) begin
          m_q.push_back(c);
          m_lline = c;
          m_lvalid = 1;
        end else if (m_drop < 16'hFFFF) begin
          m_drop++;
        end
      end
      if (m_k == DEGREE) m_busy = 0;
      else m_k = m_k + 1;
    end
    trig = 0;
    if (acc_valid) begin
      idx = int'((acc_pc >> PC_LSB) % ENTRIES);
      tag = acc_pc >> (PC_LSB + S_INDEX);
      if (!m_valid[idx] || m_tag[idx] != tag) begin
        m_valid[idx] = 1; m_tag[idx] = tag; m_last[idx] = acc_addr;
        m_stride[idx] = 0; m_conf[idx] = 0;
      end else begin
        d = acc_addr - m_last[idx];
        if (d != 0) begin
          if (d == m_stride[idx]) begin
            nc = (m_conf[idx] == CONF_MAX) ? CONF_MAX : m_conf[idx] + 1;
            trig = enable && (d != 0) && nc >= CONF_THRESH;
            m_conf[idx] = nc;
          end else begin
            m_stride[idx] = d;
            m_conf[idx] = 0;
          end
          m_last[idx] = acc_addr;
        end
      end
      if (trig) begin
        m_busy = 1; m_base = acc_addr; m_gstride = d; m_k = 1;
      end
    end
  endfunction

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] addr,
                      input logic resp, input logic en);
    acc_valid = v; acc_pc = pc; acc_addr = addr; pf_resp = resp; enable = en;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pf_read", {31'd0, pf_read}, {31'd0, m_q.size() != 0});
    chk("pf_addr", pf_addr, (m_q.size() != 0) ? m_q[0] : 32'd0);
    chk("drop_cnt", {16'd0, drop_cnt}, 32'(m_drop));
  endtask

  task automatic acc(input logic [31:0] pc, input logic [31:0] addr);
    step(1'b1, pc, addr, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic resp);
    step(1'b0, 32'd0, 32'd0, resp, 1'b1);
  endtask

  logic [31:0] rpc [5];
  logic [31:0] raddr [5];
  logic [31:0] rstr [5];
  logic [31:0] strides [6];

  initial begin
    model_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("reset_read", {31'd0, pf_read}, 32'd0);
    chk("reset_drop", {16'd0, drop_cnt}, 32'd0);
    rst = 1'b0;

    // ascending 0x40 stream
    acc(32'h100, 32'h1000); acc(32'h100, 32'h1040); acc(32'h100, 32'h1080);
    chk("t1_quiet", {31'd0, pf_read}, 32'd0);
    acc(32'h100, 32'h10C0);
    idle(1'b0);
    chk("t1_first", pf_addr, 32'h1100);
    idle(1'b1);
    chk("t1_second", pf_addr, 32'h1140);
    idle(1'b1);
    chk("t1_empty", {31'd0, pf_read}, 32'd0);

    // descending stream
    acc(32'h200, 32'h3100); acc(32'h200, 32'h30C0); acc(32'h200, 32'h3080); acc(32'h200, 32'h3040);
    idle(1'b0);
    chk("t2_first", pf_addr, 32'h3000);
    idle(1'b1);
    chk("t2_second", pf_addr, 32'h2FC0);
    idle(1'b1);

    // sub-line stride: every candidate is in the base line
    acc(32'h300, 32'h2000); acc(32'h300, 32'h2004); acc(32'h300, 32'h2008); acc(32'h300, 32'h200C);
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("t3_none", {31'd0, pf_read}, 32'd0);
    chk("t3_drop", {16'd0, drop_cnt}, 32'd0);

    // aliasing PC evicts a trained entry
    acc(32'h100, 32'h5000); acc(32'h100, 32'h5040); acc(32'h100, 32'h5080); acc(32'h100, 32'h50C0);
    repeat (4) idle(1'b1);
    acc(32'h140, 32'h9000);
    acc(32'h100, 32'h5100); acc(32'h100, 32'h5140); acc(32'h100, 32'h5180);
    idle(1'b0); idle(1'b0);
    chk("t4_notrig", {31'd0, pf_read}, 32'd0);
    acc(32'h100, 32'h51C0);
    idle(1'b0);
    chk("t4_retrig", pf_addr, 32'h5200);
    repeat (4) idle(1'b1);

    // overflow while memory stalls
    for (int i = 0; i < 12; i++) acc(32'h404, 32'h8000 + 32'(i) * 32'h40);
    idle(1'b0); idle(1'b0);
    chk("t5_drop", {16'd0, drop_cnt}, 32'd6);
    chk("t5_h0", pf_addr, 32'h8100);
    idle(1'b1); chk("t5_h1", pf_addr, 32'h8140);
    idle(1'b1); chk("t5_h2", pf_addr, 32'h8180);
    idle(1'b1); chk("t5_h3", pf_addr, 32'h81C0);
    idle(1'b1); chk("t5_empty", {31'd0, pf_read}, 32'd0);

    // reset mid-burst with three queued requests
    for (int i = 0; i < 6; i++) acc(32'h408, 32'hA000 + 32'(i) * 32'h40);
    idle(1'b0);
    chk("t6_pre", {31'd0, pf_read}, 32'd1);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    chk("t6_read", {31'd0, pf_read}, 32'd0);
    chk("t6_addr", pf_addr, 32'd0);
    chk("t6_drop", {16'd0, drop_cnt}, 32'd0);
    idle(1'b1);
    acc(32'h404, 32'h8300); acc(32'h404, 32'h8340); acc(32'h404, 32'h8380);
    idle(1'b0); idle(1'b0);
    chk("t6_realloc", {31'd0, pf_read}, 32'd0);

    // random traffic
    strides[0] = 32'h40; strides[1] = -32'sd64; strides[2] = 32'h80;
    strides[3] = 32'h4; strides[4] = 32'h20; strides[5] = 32'hFFFF_FF00;
    rpc[0] = 32'h100; rpc[1] = 32'h140; rpc[2] = 32'h404; rpc[3] = 32'hFFFF_FFF8; rpc[4] = 32'h0123_4570;
    for (int p = 0; p < 5; p++) begin
      raddr[p] = $urandom;
      rstr[p] = strides[$urandom_range(0, 5)];
    end
    for (int n = 0; n < 3000; n++) begin
      int p;
      logic v, en, resp;
      p = $urandom_range(0, 4);
      v = ($urandom_range(0, 9) < 7);
      en = ($urandom_range(0, 9) < 8);
      resp = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 19) == 0) rstr[p] = strides[$urandom_range(0, 5)];
      if ($urandom_range(0, 29) == 0) raddr[p] = $urandom;
      else if ($urandom_range(0, 14) != 0) raddr[p] = raddr[p] + rstr[p];
      rst = ($urandom_range(0, 499) == 0);
      step(v, rpc[p], raddr[p], resp, en);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
